// File: rtl/cla_acc_pkg.sv
// Shared types and helpers for the cla_acc64 streaming accumulator.
// Optional double-buffered output is selected with CLA_ACC_DBUF_EN.
package cla_acc_pkg;

    localparam int N_WIDTH = 64;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    function automatic logic sovf_det(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb
    );
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

endpackage

// File: rtl/CLA_64_bit.sv
// 64-bit three-level carry-lookahead adder (4-bit groups).
// Group propagate/generate of the full word are exposed as pout/gout.
module CLA_64_bit (
    input  logic [63:0] input1,
    input  logic [63:0] input2,
    input  logic        cin,
    output logic [63:0] result,
    output logic        cout,
    output logic        pout,
    output logic        gout
);

    logic [63:0] g, p, c;
    logic [15:0] g1, p1, c1;
    logic [3:0]  g2, p2, c2;

    function automatic logic [3:0] la4(
        input logic [3:0] gi,
        input logic [3:0] pi,
        input logic       ci
    );
        logic [3:0] r;
        r[0] = ci;
        r[1] = gi[0] | (pi[0] & ci);
        r[2] = gi[1] | (pi[1] & gi[0])
             | (pi[1] & pi[0] & ci);
        r[3] = gi[2] | (pi[2] & gi[1])
             | (pi[2] & pi[1] & gi[0])
             | (pi[2] & pi[1] & pi[0] & ci);
        return r;
    endfunction

    function automatic logic gg(
        input logic [3:0] gi,
        input logic [3:0] pi
    );
        return gi[3] | (pi[3] & gi[2])
             | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    endfunction

    assign g = input1 & input2;
    assign p = input1 ^ input2;

    for (genvar j = 0; j < 16; j++) begin : g_lvl1
        assign g1[j]      = gg(g[4*j+:4], p[4*j+:4]);
        assign p1[j]      = &p[4*j+:4];
        assign c[4*j+:4]  = la4(g[4*j+:4], p[4*j+:4], c1[j]);
    end

    for (genvar k = 0; k < 4; k++) begin : g_lvl2
        assign g2[k]      = gg(g1[4*k+:4], p1[4*k+:4]);
        assign p2[k]      = &p1[4*k+:4];
        assign c1[4*k+:4] = la4(g1[4*k+:4], p1[4*k+:4], c2[k]);
    end

    assign gout   = gg(g2, p2);
    assign pout   = &p2;
    assign c2     = la4(g2, p2, cin);
    assign cout   = gout | (pout & cin);
    assign result = p ^ c;

endmodule

// File: rtl/cla_acc_outreg.sv
// Result register with valid/ready handshake for cla_acc64.
// Holds two entries when CLA_ACC_DBUF_EN is defined, else one.
module cla_acc_outreg
    import cla_acc_pkg::*;
#(
    parameter int N  = N_WIDTH,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [N-1:0]  ld_sum,
    input  logic [CW-1:0] ld_count,
    input  logic          ld_uwrap,
    input  logic          ld_sovf,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_uwrap,
    output logic          out_sovf
);

    logic pop;

    assign pop = out_valid & out_ready;

`ifdef CLA_ACC_DBUF_EN
    logic          v1;
    logic [N-1:0]  s1;
    logic [CW-1:0] n1;
    logic          u1, o1;

    // Entry 1 is the waiting packet; it slides forward on a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_uwrap <= 1'b0;
            out_sovf  <= 1'b0;
            v1        <= 1'b0;
            s1        <= '0;
            n1        <= '0;
            u1        <= 1'b0;
            o1        <= 1'b0;
        end else if (pop && v1) begin
            out_sum   <= s1;
            out_count <= n1;
            out_uwrap <= u1;
            out_sovf  <= o1;
            v1        <= 1'b0;
        end else if (load && out_valid && !pop) begin
            s1 <= ld_sum;
            n1 <= ld_count;
            u1 <= ld_uwrap;
            o1 <= ld_sovf;
            v1 <= 1'b1;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= ld_sum;
            out_count <= ld_count;
            out_uwrap <= ld_uwrap;
            out_sovf  <= ld_sovf;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_count <= '0;
            out_uwrap <= 1'b0;
            out_sovf  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_sum   <= ld_sum;
            out_count <= ld_count;
            out_uwrap <= ld_uwrap;
            out_sovf  <= ld_sovf;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/cla_acc64.sv
// Streaming multi-operand accumulator around CLA_64_bit.
// Define CLA_ACC_DBUF_EN to accumulate while a result waits.
module cla_acc64
    import cla_acc_pkg::*;
#(
    parameter int N  = N_WIDTH,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_sub,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_count,
    output logic          out_uwrap,
    output logic          out_sovf
);

    state_t        state, state_n;
    logic [N-1:0]  acc, op2, res;
    logic [CW-1:0] cnt, cnt_n;
    logic          uwrap, sovf;
    logic          uwrap_n, sovf_n;
    logic          cout, accept, load, block;
    logic          pout_unused, gout_unused;

    assign op2 = in_sub ? ~in_data : in_data;

    CLA_64_bit u_cla (
        .input1 (acc),
        .input2 (op2),
        .cin    (in_sub),
        .result (res),
        .cout   (cout),
        .pout   (pout_unused),
        .gout   (gout_unused)
    );

    assign cnt_n   = (&cnt) ? cnt : cnt + CW'(1);
    assign uwrap_n = uwrap | (cout ^ in_sub);
    assign sovf_n  = sovf
                   | sovf_det(acc[N-1], op2[N-1], res[N-1]);
    assign accept  = in_valid & in_ready;
    assign load    = accept & in_last;

    // Stall input only when no slot will be free for this result.
`ifdef CLA_ACC_DBUF_EN
    assign block = out_valid & ~out_ready;
`else
    assign block = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n  = state;
        in_ready = 1'b0;
        unique case (state)
            ACCUM: begin
                in_ready = 1'b1;
                if (load && block) begin
                    state_n = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = ACCUM;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            uwrap <= 1'b0;
            sovf  <= 1'b0;
        end else if (load) begin
            acc   <= '0;
            cnt   <= '0;
            uwrap <= 1'b0;
            sovf  <= 1'b0;
        end else if (accept) begin
            acc   <= res;
            cnt   <= cnt_n;
            uwrap <= uwrap_n;
            sovf  <= sovf_n;
        end
    end

    cla_acc_outreg #(
        .N  (N),
        .CW (CW)
    ) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .ld_sum    (res),
        .ld_count  (cnt_n),
        .ld_uwrap  (uwrap_n),
        .ld_sovf   (sovf_n),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_uwrap (out_uwrap),
        .out_sovf  (out_sovf)
    );

endmodule

// File: tb/tb_cla_acc64.sv
// Scoreboard bench for cla_acc64: directed packets, hold and reset.
// Honours CLA_ACC_DBUF_EN for the double-buffer hold scenario.
module tb_cla_acc64;

    typedef struct packed {
        logic [63:0] sum;
        logic [15:0] cnt;
        logic        uw;
        logic        so;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [63:0] in_data;
    logic        in_sub, in_last;
    logic        out_valid, out_ready;
    logic [63:0] out_sum;
    logic [15:0] out_count;
    logic        out_uwrap, out_sovf;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    cla_acc64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sub    (in_sub),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_uwrap (out_uwrap),
        .out_sovf  (out_sovf)
    );

    task automatic chk(input string nm,
                       input logic [95:0] act,
                       input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] s,
                        input logic [15:0] c,
                        input logic u, input logic o);
        exp_t e;
        e.sum = s; e.cnt = c; e.uw = u; e.so = o;
        q.push_back(e);
    endtask

    task automatic beat(input logic [63:0] d,
                        input logic s, input logic l);
        int n;
        in_valid = 1'b1; in_data = d;
        in_sub = s; in_last = l;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            chk("in_ready_timeout", 96'd0, 96'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk(nm, {out_valid, out_sum, out_count,
                 out_uwrap, out_sovf}, 96'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 96'd1, 96'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", {out_sum, out_count,
                               out_uwrap, out_sovf}, 96'(e));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
        in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        #12;
        chk_zero("reset_outputs");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", 96'(in_ready), 96'd1);
        chk_zero("idle_outputs");

        // 5+7+10
        beat(64'd5, 1'b0, 1'b0);
        beat(64'd7, 1'b0, 1'b0);
        push(64'd22, 16'd3, 1'b0, 1'b0);
        beat(64'd10, 1'b0, 1'b1);
        chk("t1_valid", 96'(out_valid), 96'd1);
        @(posedge clk); #1;
        chk("t1_valid_one_cycle", 96'(out_valid), 96'd0);

        // unsigned wrap
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(64'd1, 16'd2, 1'b1, 1'b0);
        beat(64'd2, 1'b0, 1'b1);
        @(posedge clk); #1;

        // signed overflow
        beat(64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        push(64'h8000_0000_0000_0000, 16'd2, 1'b0, 1'b1);
        beat(64'd1, 1'b0, 1'b1);
        @(posedge clk); #1;

        // single subtract beat
        push(64'hFFFF_FFFF_FFFF_FFFD, 16'd1, 1'b1, 1'b0);
        beat(64'd3, 1'b1, 1'b1);
        @(posedge clk); #1;

        // mixed add/sub with idle gaps and stray out_ready
        beat(64'd100, 1'b0, 1'b0);
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk); #1;
        chk("gap_no_valid", 96'(out_valid), 96'd0);
        beat(64'd30, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        push(64'd75, 16'd3, 1'b0, 1'b0);
        beat(64'd5, 1'b0, 1'b1);
        @(posedge clk); #1;

        // hold with out_ready low
        out_ready = 1'b0;
        push(64'd9, 16'd1, 1'b0, 1'b0);
        beat(64'd9, 1'b0, 1'b1);
`ifdef CLA_ACC_DBUF_EN
        push(64'd2, 16'd2, 1'b0, 1'b0);
`endif
        for (int i = 0; i < 4; i++) begin
`ifdef CLA_ACC_DBUF_EN
            in_valid = (i < 2); in_data = 64'd1;
            in_sub = 1'b0; in_last = (i == 1);
            chk("hold_in_ready", 96'(in_ready),
                96'(i < 2));
`else
            chk("hold_in_ready", 96'(in_ready), 96'd0);
`endif
            chk("hold_stable", {out_valid, out_sum,
                out_count}, {1'b1, 64'd9, 16'd1});
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
`ifdef CLA_ACC_DBUF_EN
        chk("dbuf_no_gap", {out_valid, out_sum},
            {1'b1, 64'd2});
        @(posedge clk); #1;
`endif
        chk("hold_release", 96'(out_valid), 96'd0);

        // reset mid-hold and mid-packet
        out_ready = 1'b0;
        beat(64'd6, 1'b0, 1'b1);
        chk("pre_reset_valid", 96'(out_valid), 96'd1);
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_ready", 96'(in_ready), 96'd1);
        beat(64'd11, 1'b0, 1'b0);
        beat(64'd12, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_zero("reset_mid_packet");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        push(64'd4, 16'd1, 1'b0, 1'b0);
        beat(64'd4, 1'b0, 1'b1);
        chk("after_reset_valid", 96'(out_valid), 96'd1);

        for (int n = 0; n < 50 && q.size() != 0; n++) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", 96'(q.size()), 96'd0);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
